hack_alu_pipe: RTL and testbench

//   Two-stage pipelined Hack ALU. Consumes the bitwise-And path (16-bit And) and the

---
 rtl/hack_alu_pipe_if.sv | 23 ++
 rtl/hack_alu_pipe.sv | 71 +++++++
 tb/tb_hack_alu_pipe.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/hack_alu_pipe_if.sv
// Valid/ready bus for the pipelined Hack ALU: operand request in, result response out.
interface hack_alu_pipe_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [5:0]       ctrl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zr;
  logic             ng;

  modport master (
    output in_valid, x, y, ctrl, out_ready,
    input  in_ready, out_valid, out, zr, ng
  );

  modport slave (
    input  in_valid, x, y, ctrl, out_ready,
    output in_ready, out_valid, out, zr, ng
  );
endinterface

// File: rtl/hack_alu_pipe.sv
// Two-stage Hack ALU: stage 1 applies zx/nx/zy/ny, stage 2 does add/and, no and flags.
// Each stage stalls only when it holds data the next stage cannot take.
module hack_alu_pipe #(
  parameter int WIDTH = 16
) (
  input logic           clk,
  input logic           reset,
  hack_alu_pipe_if.slave bus
);
  typedef struct packed {
    logic [WIDTH-1:0] xs;
    logic [WIDTH-1:0] ys;
    logic             f;
    logic             no;
  } s1_t;

  // vld_pipe[1] = stage-1 occupied, vld_pipe[2] = stage-2 (output) occupied
  logic [2:1]       vld_pipe;
  logic             adv1, adv2;
  s1_t              s1_d, s1_q;
  logic [WIDTH-1:0] xz, yz, r, res_d;
  logic [WIDTH-1:0] out_q;
  logic             zr_q, ng_q;

  assign adv2 = !vld_pipe[2] || bus.out_ready;
  assign adv1 = !vld_pipe[1] || adv2;

  always_comb begin
    xz      = bus.ctrl[5] ? '0 : bus.x;
    yz      = bus.ctrl[3] ? '0 : bus.y;
    s1_d.xs = bus.ctrl[4] ? ~xz : xz;
    s1_d.ys = bus.ctrl[2] ? ~yz : yz;
    s1_d.f  = bus.ctrl[1];
    s1_d.no = bus.ctrl[0];
  end

  always_comb begin
    r     = s1_q.f ? (s1_q.xs + s1_q.ys) : (s1_q.xs & s1_q.ys);
    res_d = s1_q.no ? ~r : r;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      out_q    <= '0;
      zr_q     <= 1'b0;
      ng_q     <= 1'b0;
    end else begin
      if (adv1) begin
        vld_pipe[1] <= bus.in_valid;
        if (bus.in_valid) s1_q <= s1_d;
      end
      // Bubbles leave stage-2 data untouched; only out_valid qualifies it.
      if (adv2) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          out_q <= res_d;
          zr_q  <= (res_d == '0);
          ng_q  <= res_d[WIDTH-1];
        end
      end
    end
  end

  assign bus.in_ready  = adv1;
  assign bus.out_valid = vld_pipe[2];
  assign bus.out       = out_q;
  assign bus.zr        = zr_q;
  assign bus.ng        = ng_q;
endmodule

// File: tb/tb_hack_alu_pipe.sv
// Scoreboard bench for hack_alu_pipe: driver pushes expected results on input transfer,
// monitor pops and compares on every output transfer.
module tb_hack_alu_pipe;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  logic [15:0] sb[$];
  bit rnd_on = 1'b0;

  hack_alu_pipe_if #(.WIDTH(16)) bus ();

  hack_alu_pipe #(.WIDTH(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Hack ALU semantics: zero, then negate each operand; add or and; optionally negate result.
  function automatic logic [15:0] ref_alu(input logic [15:0] x, input logic [15:0] y,
                                          input logic [5:0] c);
    logic [15:0] a, b, res;
    a = c[5] ? 16'h0000 : x;
    if (c[4]) a = ~a;
    b = c[3] ? 16'h0000 : y;
    if (c[2]) b = ~b;
    if (c[1]) res = 16'((32'(a) + 32'(b)) % 32'h10000);
    else      res = a & b;
    if (c[0]) res = ~res;
    return res;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with in_valid dropped.
  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c,
                      input logic [15:0] e);
    int n = 0;
    bit done = 1'b0;
    bus.in_valid = 1'b1;
    bus.x = x;
    bus.y = y;
    bus.ctrl = c;
    while (!done && n < 200) begin
      #4;
      if (bus.in_ready) begin
        sb.push_back(e);
        done = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b0;
    if (!done) check("send_timeout", 32'(n), 32'd0);
  endtask

  task automatic wait_drain(input int lim);
    int n = 0;
    while (sb.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Monitor
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (!reset && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out got=%h exp=none", bus.out);
        end else begin
          e = sb.pop_front();
          check("out", 32'(bus.out), 32'(e));
          check("zr", 32'(bus.zr), 32'(e == 16'h0000));
          check("ng", 32'(bus.ng), 32'(e[15]));
        end
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.x = '0;
    bus.y = '0;
    bus.ctrl = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #4;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out", 32'(bus.out), 32'd0);
    check("rst_zr", 32'(bus.zr), 32'd0);
    check("rst_ng", 32'(bus.ng), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);

    // 5+3 with latency probe
    bus.in_valid = 1'b1;
    bus.x = 16'd5;
    bus.y = 16'd3;
    bus.ctrl = 6'b000010;
    #4;
    check("t1_in_ready", 32'(bus.in_ready), 32'd1);
    sb.push_back(16'h0008);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #4;
    check("t1_lat1", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    #4;
    check("t1_lat2", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    wait_drain(20);

    send(16'h00FF, 16'h0F0F, 6'b000000, 16'h000F);
    send(16'h00FF, 16'h0F0F, 6'b101010, 16'h0000);
    send(16'h00FF, 16'h0F0F, 6'b111111, 16'h0001);
    send(16'h0003, 16'h0005, 6'b010011, 16'hFFFE);
    send(16'hFFFF, 16'h0001, 6'b000010, 16'h0000);
    wait_drain(20);

    // Back-pressure: two entries fill the pipe, output must hold
    bus.out_ready = 1'b0;
    send(16'd1, 16'd2, 6'b000010, 16'h0003);
    send(16'd7, 16'd4, 6'b000010, 16'h000B);
    #4;
    check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #4;
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_out", 32'(bus.out), 32'h0003);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    send(16'h8000, 16'h0001, 6'b000000, 16'h0000);
    send(16'h1234, 16'h0000, 6'b001100, 16'h1234);
    wait_drain(20);

    // Reset with two in flight
    bus.out_ready = 1'b0;
    send(16'd9, 16'd9, 6'b000010, 16'd18);
    send(16'd1, 16'd1, 6'b000010, 16'd2);
    reset = 1'b1;
    @(negedge clk);
    #4;
    check("mr_out_valid", 32'(bus.out_valid), 32'd0);
    check("mr_out", 32'(bus.out), 32'd0);
    check("mr_zr", 32'(bus.zr), 32'd0);
    check("mr_ng", 32'(bus.ng), 32'd0);
    check("mr_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #4;
      check("mr_no_stale", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
    end

    // Random traffic with random back-pressure
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(negedge clk);
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    @(negedge clk);
    for (int i = 0; i < 10000; i++) begin
      logic [15:0] rx, ry;
      logic [5:0] rc;
      rx = 16'($urandom);
      ry = 16'($urandom);
      rc = 6'($urandom);
      if (i % 7 == 0) rx = 16'hFFFF;
      if (i % 11 == 0) ry = 16'h0000;
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send(rx, ry, rc, ref_alu(rx, ry, rc));
    end
    rnd_on = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.out_ready = 1'b1;
    wait_drain(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
